// File: rtl/fn_seq_4.sv
// Bit-serial bitwise logic sequencer: streams operands LSB first to an external
// combinational logic stage and reassembles the returned bits into a result word.
module fn_seq_4 #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [1:0]       op_sel,
    output logic             a,
    output logic             b,
    output logic [1:0]       sel,
    input  logic             y,
    output logic [WIDTH-1:0] res,
    output logic             res_valid,
    input  logic             res_ready
);

    localparam int CW = $clog2(WIDTH) + 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    logic [1:0]       state_r;
    logic [WIDTH-1:0] shift_a_r;
    logic [WIDTH-1:0] shift_b_r;
    logic [1:0]       op_reg_r;
    logic [CW-1:0]    cnt_r;
    logic [WIDTH-1:0] res_r;
    logic             run_s;

    // Sequencer state, operand shifters, bit counter and result assembly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            shift_a_r <= '0;
            shift_b_r <= '0;
            op_reg_r  <= 2'b00;
            cnt_r     <= '0;
            res_r     <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        shift_a_r <= op_a;
                        shift_b_r <= op_b;
                        op_reg_r  <= op_sel;
                        cnt_r     <= '0;
                        res_r     <= '0;
                        state_r   <= RUN;
                    end else begin
                        state_r   <= IDLE;
                    end
                end
                RUN: begin
                    // Returned bit enters at the MSB so the LSB-first stream lands in order.
                    res_r     <= {y, res_r[WIDTH-1:1]};
                    shift_a_r <= {1'b0, shift_a_r[WIDTH-1:1]};
                    shift_b_r <= {1'b0, shift_b_r[WIDTH-1:1]};
                    cnt_r     <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
                    if (cnt_r == CNT_LAST) begin
                        state_r <= DONE;
                    end else begin
                        state_r <= RUN;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        state_r <= IDLE;
                    end else begin
                        state_r <= DONE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign run_s     = (state_r == RUN);
    assign in_ready  = (state_r == IDLE);
    assign res_valid = (state_r == DONE);
    assign a         = run_s & shift_a_r[0];
    assign b         = run_s & shift_b_r[0];
    assign sel       = op_reg_r;
    assign res       = res_r;

endmodule

// File: tb/tb_fn_seq_4.sv
// Directed testbench for fn_seq_4 with a reference AND/OR/XOR/XNOR stage
// closing the a/b/sel -> y loop.
module tb_fn_seq_4;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] op_a;
    logic [3:0] op_b;
    logic [1:0] op_sel;
    logic       a;
    logic       b;
    logic [1:0] sel;
    logic       y;
    logic [3:0] res;
    logic       res_valid;
    logic       res_ready;

    int tests_run;
    int tests_failed;

    fn_seq_4 #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .op_sel    (op_sel),
        .a         (a),
        .b         (b),
        .sel       (sel),
        .y         (y),
        .res       (res),
        .res_valid (res_valid),
        .res_ready (res_ready)
    );

    // Reference logic stage.
    always_comb begin
        case (sel)
            2'b00:   y = a & b;
            2'b01:   y = a | b;
            2'b10:   y = a ^ b;
            default: y = ~(a ^ b);
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Accept one command, check latency and result, then complete the handshake.
    task automatic run_cmd(input logic [3:0] oa, input logic [3:0] ob, input logic [1:0] os,
                           input logic [3:0] exp, input string tag);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        op_a = oa;
        op_b = ob;
        op_sel = os;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk({tag, "_early_valid"}, 32'(res_valid), 32'd0);
            step();
        end
        chk({tag, "_res_valid"}, 32'(res_valid), 32'd1);
        chk({tag, "_res"}, 32'(res), 32'(exp));
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        chk({tag, "_idle"}, 32'(in_ready), 32'd1);
        chk({tag, "_sel_hold"}, 32'(sel), 32'(os));
    endtask

    logic [3:0] tab_exp [4];
    logic [3:0] av;
    logic [3:0] bv;
    logic [3:0] b2b_a [3];
    logic [3:0] b2b_b [3];
    logic [1:0] b2b_s [3];
    logic [3:0] b2b_e [3];

    initial begin
        tests_run = 0;
        tests_failed = 0;
        rst_n = 1'b0;
        in_valid = 1'b0;
        res_ready = 1'b0;
        op_a = 4'h0;
        op_b = 4'h0;
        op_sel = 2'b00;
        #3;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_res", 32'(res), 32'd0);
        chk("rst_sel", 32'(sel), 32'd0);
        chk("rst_ab", 32'({a, b}), 32'd0);
        step();
        step();
        rst_n = 1'b1;
        step();

        // Four logic ops on the same operand pair.
        tab_exp[0] = 4'b1000;
        tab_exp[1] = 4'b1110;
        tab_exp[2] = 4'b0110;
        tab_exp[3] = 4'b1001;
        for (int k = 0; k < 4; k++) begin
            run_cmd(4'b1100, 4'b1010, 2'(k), tab_exp[k], $sformatf("op%0d", k));
        end

        // Serial trace of a and b.
        op_a = 4'b0001;
        op_b = 4'b0011;
        op_sel = 2'b10;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            av[i] = a;
            bv[i] = b;
            step();
        end
        chk("trace_a", 32'(av), 32'(4'b0001));
        chk("trace_b", 32'(bv), 32'(4'b0011));
        chk("trace_res", 32'(res), 32'(4'b0010));
        chk("trace_valid", 32'(res_valid), 32'd1);
        chk("trace_ab_done", 32'({a, b}), 32'd0);
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;

        // Back-pressure: held DONE ignores new commands.
        op_a = 4'b1100;
        op_b = 4'b1010;
        op_sel = 2'b00;
        in_valid = 1'b1;
        step();
        op_a = 4'b0101;
        op_b = 4'b0011;
        op_sel = 2'b01;
        for (int i = 0; i < 4; i++) step();
        for (int i = 0; i < 5; i++) begin
            chk("bp_res", 32'(res), 32'(4'b1000));
            chk("bp_valid", 32'(res_valid), 32'd1);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_sel", 32'(sel), 32'd0);
            step();
        end
        in_valid = 1'b0;
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        chk("bp_release_idle", 32'(in_ready), 32'd1);
        chk("bp_release_valid", 32'(res_valid), 32'd0);

        // Back-to-back commands, one per six cycles.
        b2b_a[0] = 4'b1100; b2b_b[0] = 4'b1010; b2b_s[0] = 2'b01; b2b_e[0] = 4'b1110;
        b2b_a[1] = 4'b0011; b2b_b[1] = 4'b0101; b2b_s[1] = 2'b10; b2b_e[1] = 4'b0110;
        b2b_a[2] = 4'b1111; b2b_b[2] = 4'b0110; b2b_s[2] = 2'b00; b2b_e[2] = 4'b0110;
        op_a = b2b_a[0];
        op_b = b2b_b[0];
        op_sel = b2b_s[0];
        in_valid = 1'b1;
        res_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("b2b%0d_in_ready", k), 32'(in_ready), 32'd1);
            step();
            for (int i = 0; i < 3; i++) step();
            chk($sformatf("b2b%0d_busy", k), 32'(res_valid), 32'd0);
            step();
            chk($sformatf("b2b%0d_valid", k), 32'(res_valid), 32'd1);
            chk($sformatf("b2b%0d_res", k), 32'(res), 32'(b2b_e[k]));
            if (k < 2) begin
                op_a = b2b_a[k+1];
                op_b = b2b_b[k+1];
                op_sel = b2b_s[k+1];
            end else begin
                in_valid = 1'b0;
            end
            step();
            chk($sformatf("b2b%0d_idle", k), 32'(in_ready), 32'd1);
        end
        res_ready = 1'b0;
        step();

        // Asynchronous reset during RUN cycle 2.
        op_a = 4'b1111;
        op_b = 4'b1111;
        op_sel = 2'b01;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        chk("pre_rst_a", 32'(a), 32'd1);
        chk("pre_rst_in_ready", 32'(in_ready), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ab", 32'({a, b}), 32'd0);
        chk("mid_rst_sel", 32'(sel), 32'd0);
        chk("mid_rst_res", 32'(res), 32'd0);
        chk("mid_rst_valid", 32'(res_valid), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        step();
        #3;
        rst_n = 1'b1;
        step();
        run_cmd(4'b1111, 4'b0000, 2'b11, 4'b0000, "post_rst");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
